// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pseudo-random source with run-time seed load, zero-load
// recovery, counted bursts and a period-wrap pulse. With the default
// parameters it reproduces the legacy 4-bit sequence (x^4 + x^3 + 1).
//
// state | meaning
// IDLE  | steps only when en_i is high; accepts start_i
// BURST | steps every cycle until the remaining-step count runs out
module lfsr_gen #(
  parameter int unsigned            WIDTH = 4,
  parameter logic [WIDTH-1:0]       TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0]       SEED  = 4'b0001,
  parameter int unsigned            CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic [WIDTH-1:0] data_o,
  output logic             fb_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic [WIDTH-1:0] sreg_next;
  logic             step;

  assign fb        = ^(sreg_q & TAPS);
  assign sreg_next = {sreg_q[WIDTH-2:0], fb};

  // Next-state logic: load overrides everything, then start, then en.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    step     = 1'b0;

    if (load_i) begin
      // An all-zero value would lock the register up, so substitute SEED.
      if (load_val_i == '0) begin
        sreg_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        sreg_d   = load_val_i;
      end
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (burst_len_i != '0) begin
              state_d = BURST;
              rem_d   = burst_len_i;
            end else begin
              done_d  = 1'b1;
            end
          end else if (en_i) begin
            step = 1'b1;
          end
        end
        BURST: begin
          step  = 1'b1;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (step) begin
      sreg_d = sreg_next;
      wrap_d = (sreg_next == SEED);
    end
  end

  // State, shift register, counter and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sreg_q   <= SEED;
      rem_q    <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign data_o   = sreg_q;
  assign fb_o     = fb;
  assign busy_o   = (state_q == BURST);
  assign done_o   = done_q;
  assign wrap_o   = wrap_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 4-bit instance plus an 8-bit
// instance for the full-period wrap check.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en = 1'b0, load = 1'b0, start = 1'b0;
  logic [3:0] load_val = '0;
  logic [7:0] burst_len = '0;
  logic [3:0] data;
  logic       fb, busy, done, wrap, lockup;

  logic       en8 = 1'b0;
  logic [7:0] data8;
  logic       fb8, busy8, done8, wrap8, lockup8;

  int checks = 0;
  int passed = 0;

  logic [3:0] seq [0:15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001,
                             4'b0011, 4'b0110, 4'b1101, 4'b1010,
                             4'b0101, 4'b1011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load),
    .load_val_i(load_val), .start_i(start), .burst_len_i(burst_len),
    .data_o(data), .fb_o(fb), .busy_o(busy), .done_o(done),
    .wrap_o(wrap), .lockup_o(lockup)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .CNT_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en8), .load_i(1'b0),
    .load_val_i(8'h00), .start_i(1'b0), .burst_len_i(8'h00),
    .data_o(data8), .fb_o(fb8), .busy_o(busy8), .done_o(done8),
    .wrap_o(wrap8), .lockup_o(lockup8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (data !== 4'b0001) $display("FAIL reset_data got=%b exp=0001", data); else passed++;
    checks++; if ({busy, done, wrap, lockup} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, wrap, lockup}); else passed++;
    checks++; if (fb !== 1'b0) $display("FAIL reset_fb got=%b exp=0", fb); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_free_run();
    int wraps = 0;
    en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (data !== seq[i]) $display("FAIL run_data step=%0d got=%b exp=%b", i, data, seq[i]); else passed++;
      checks++; if (wrap !== (i == 15)) $display("FAIL run_wrap step=%0d got=%b exp=%b", i, wrap, (i == 15)); else passed++;
      if (i < 15) begin
        checks++; if (fb !== seq[i+1][0]) $display("FAIL run_fb step=%0d got=%b exp=%b", i, fb, seq[i+1][0]); else passed++;
      end
      if (wrap) wraps++;
    end
    en = 1'b0;
    checks++; if (wraps != 1) $display("FAIL run_wrap_count got=%0d exp=1", wraps); else passed++;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 4'b1010;
    tick();
    load = 1'b0; en = 1'b1;
    checks++; if (data !== 4'b1010) $display("FAIL load_data got=%b exp=1010", data); else passed++;
    checks++; if (lockup !== 1'b0) $display("FAIL load_lockup got=%b exp=0", lockup); else passed++;
    tick();
    checks++; if (data !== 4'b0101) $display("FAIL load_step1 got=%b exp=0101", data); else passed++;
    tick();
    en = 1'b0;
    checks++; if (data !== 4'b1011) $display("FAIL load_step2 got=%b exp=1011", data); else passed++;
    checks++; if (lockup !== 1'b0) $display("FAIL load_lockup2 got=%b exp=0", lockup); else passed++;
  endtask

  task automatic test_lockup();
    load = 1'b1; load_val = 4'b0000;
    tick();
    load = 1'b0; en = 1'b1;
    checks++; if (data !== 4'b0001) $display("FAIL zero_data got=%b exp=0001", data); else passed++;
    checks++; if (lockup !== 1'b1) $display("FAIL zero_lockup got=%b exp=1", lockup); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL zero_wrap got=%b exp=0", wrap); else passed++;
    tick();
    en = 1'b0;
    checks++; if (data !== 4'b0010) $display("FAIL zero_step got=%b exp=0010", data); else passed++;
    checks++; if (lockup !== 1'b0) $display("FAIL zero_lockup_clr got=%b exp=0", lockup); else passed++;
  endtask

  task automatic test_burst();
    int dones = 0;
    load = 1'b1; load_val = 4'b0001;
    tick();
    load = 1'b0;
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0; burst_len = 8'd0;
    checks++; if (data !== 4'b0001 || busy !== 1'b1)
      $display("FAIL burst_start got=%b/%b exp=0001/1", data, busy); else passed++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (data !== seq[k]) $display("FAIL burst_data k=%0d got=%b exp=%b", k, data, seq[k]); else passed++;
      checks++; if (busy !== (k < 5)) $display("FAIL burst_busy k=%0d got=%b exp=%b", k, busy, (k < 5)); else passed++;
      checks++; if (done !== (k == 5)) $display("FAIL burst_done k=%0d got=%b exp=%b", k, done, (k == 5)); else passed++;
    end
    tick();
    checks++; if (done !== 1'b0 || data !== 4'b0110)
      $display("FAIL burst_after got=%b/%b exp=0/0110", done, data); else passed++;
    start = 1'b1; burst_len = 8'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data !== 4'b0110)
      $display("FAIL zero_len got=%b/%b/%b exp=1/0/0110", done, busy, data); else passed++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL zero_len_clr got=%b exp=0", done); else passed++;
  endtask

  task automatic test_abort();
    int dones = 0;
    load = 1'b1; load_val = 4'b0001;
    tick();
    load = 1'b0;
    start = 1'b1; burst_len = 8'd10;
    tick();
    burst_len = 8'd1;
    tick();
    checks++; if (data !== 4'b0010) $display("FAIL abort_step1 got=%b exp=0010", data); else passed++;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL start_ignored got=%b/%b exp=1/0", busy, done); else passed++;
    load = 1'b1; load_val = 4'b1111;
    tick();
    load = 1'b0;
    checks++; if (data !== 4'b1111 || busy !== 1'b0)
      $display("FAIL abort_load got=%b/%b exp=1111/0", data, busy); else passed++;
    for (int k = 0; k < 12; k++) begin
      if (done) dones++;
      tick();
    end
    checks++; if (dones != 0 || data !== 4'b1111)
      $display("FAIL abort_nodone got=%0d/%b exp=0/1111", dones, data); else passed++;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 4'b0001;
    tick();
    load = 1'b0;
    start = 1'b1; burst_len = 8'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data !== 4'b0001 || busy !== 1'b0)
      $display("FAIL async_reset got=%b/%b exp=0001/0", data, busy); else passed++;
    #2 rst_n = 1'b1;
    tick();
    tick();
    checks++; if (data !== 4'b0001 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL post_reset got=%b/%b/%b exp=0001/0/0", data, busy, done); else passed++;
  endtask

  task automatic test_wrap8();
    int wraps = 0;
    int last = 0;
    checks++; if (data8 !== 8'h01) $display("FAIL w8_start got=%h exp=01", data8); else passed++;
    en8 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (wrap8) begin
        wraps++;
        last = i;
      end
    end
    en8 = 1'b0;
    checks++; if (wraps != 1 || last != 255)
      $display("FAIL w8_wrap got=%0d@%0d exp=1@255", wraps, last); else passed++;
    checks++; if (data8 !== 8'h01) $display("FAIL w8_data got=%h exp=01", data8); else passed++;
    tick();
    checks++; if (wrap8 !== 1'b0) $display("FAIL w8_wrap_clr got=%b exp=0", wrap8); else passed++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_lockup();
    test_burst();
    test_abort();
    test_async_reset();
    test_wrap8();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random source. Successor to the fixed 4-bit generator.
- Adds:
  - configurable width and tap mask
  - run-time seed load with all-zero lock-up protection
  - a counted burst mode with a done pulse
  - a period-wrap indicator
- Feeds test-pattern and random-delay logic. With default parameters it produces the same sequence as the 4-bit generator.

Parameters:
- WIDTH, 4: LFSR register width; legal range 2..32.
- TAPS, 4'b1100 (WIDTH bits): feedback mask; feedback bit = XOR of sreg[i] for every i with TAPS[i]=1.
- SEED, 4'b0001 (WIDTH bits): value applied on reset and on zero-load recovery; must be nonzero.
- CNT_W, 8: width of the burst length and of the remaining-step counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  advance one step per cycle while IDLE.
- load  in  1  load load_val into the register this cycle.
- load_val  in  WIDTH  seed value to load.
- start  in  1  begin a burst; sampled only while IDLE.
- burst_len  in  CNT_W  number of steps in the burst; sampled with start.
- data_out  out  WIDTH  current register value (sreg).
- fb_out  out  1  combinational feedback bit of the current sreg.
- busy  out  1  high while in BURST.
- done  out  1  one-cycle pulse at the end of a burst.
- wrap  out  1  one-cycle pulse: a step has just produced sreg == SEED.
- lockup  out  1  one-cycle pulse: a zero load was replaced by SEED.

Behaviour:
- Step: sreg <= {sreg[WIDTH-2:0], fb}. Defaults give a period of 15: 0001→0010→0100→1001→0011→0110→1101→1010→0101→1011→0111→1111→1110→1100→1000→0001.
- Reset (rst=0, asynchronous):
  - sreg=SEED, FSM=IDLE, remaining=0.
  - busy=0, done=0, wrap=0, lockup=0.
  - fb_out follows SEED.
- FSM states: IDLE and BURST.
- Priority each cycle: load > start > en.
- load=1, any state:
  - sreg <= load_val, or SEED if load_val==0. In the SEED case lockup=1 the next cycle.
  - FSM <= IDLE. An active burst is aborted without a done pulse.
  - No step and no wrap this cycle.
- IDLE:
  - start=1 with burst_len>0: FSM <= BURST, remaining <= burst_len. No step this cycle; en is ignored.
  - start=1 with burst_len==0: no step, stay IDLE, done=1 the next cycle.
  - Otherwise, en=1 steps once.
- BURST:
  - Steps every cycle; en and start are ignored.
  - remaining decrements on each step.
  - On the step where remaining==1: FSM <= IDLE, done=1 the next cycle (coincident with busy falling).
  - A burst of L steps keeps busy high exactly L cycles.
- wrap: registered. High in the cycle after a step whose new value equals SEED. Never set by load or reset.
- done, wrap and lockup are single-cycle registered pulses, cleared the following cycle.
- Latency: data_out updates one cycle after the qualifying input edge.
- Simultaneous events:
  - load+start: load wins, start is dropped.
  - load during BURST: abort, load applied.
  - Reset mid-burst: immediate return to IDLE with SEED.

Test Plan:
- Reset, then en=1 for 15 cycles → data_out follows the sequence above; wrap pulses exactly once, the cycle data_out returns to 0001.
- load=1, load_val=4'b1010, then en=1 for 2 cycles → 1010, 0101, 1011; lockup stays 0.
- load=1, load_val=0 → data_out=0001, lockup=1 for one cycle, then further steps proceed normally (no stuck-at-zero).
- From 0001, start=1, burst_len=5, en held 0 → busy high 5 cycles; data_out ends at 0110; done pulses once as busy falls. Also: start with burst_len=0 → done pulses, data_out unchanged.
- Burst of 10 started; load_val=4'b1111 applied on its 3rd step → busy drops, data_out=1111, no done pulse. Also: start while busy is ignored.
- Assert rst=0 asynchronously mid-burst (no clock edge) → data_out=0001 and busy=0 immediately; with WIDTH=8, TAPS=8'hB8, SEED=1, en=1 for 255 cycles → wrap pulses only on cycle 255.
